rv_dmem_responder: RTL and testbench

- Data-memory responder for the MEM stage of the 5-stage RV pipeline.
- Consumes the memread/memwrite control produced by instruction decode and carried through the EX/MEM register, together with the ALU address and the store data.
- Services each request from an internal word array with a fixed, parameterised latency.
- Holds the pipeline with stall until the access completes, then returns load data with a one-cycle valid.

---
 rtl/rv_dmem_responder.sv | 85 ++++++++
 tb/tb_rv_dmem_responder.sv | 119 +++++++++++
 2 files changed

// File: rtl/rv_dmem_responder.sv
// rv_dmem_responder: MEM-stage data memory with fixed latency, pipeline stall and completion pulses
// ports: clk/rst; memread, memwrite, addr, wdata request from EX/MEM; rdata/rvalid load result;
//        wdone store completion; stall pipeline hold; err misaligned or both-request flag
module rv_dmem_responder #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int DEPTH = 1024,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          memread,
  input  logic          memwrite,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
  output logic          wdone,
  output logic          stall,
  output logic          err
);
  localparam int OB = $clog2(DW / 8);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(LAT + 1);
  if (LAT < 1 || LAT > 15) begin : g_lat_chk
    $error("rv_dmem_responder: LAT must be in 1..15");
  end
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic op_rd, both, mis;
  logic [IW-1:0] idx;
  logic [DW-1:0] wd, dreg;
  logic [DW-1:0] mem [DEPTH];
  logic req, accept, done, mis_in;
  logic [IW-1:0] idx_in;
  logic unused_addr;
  assign req = memread | memwrite;
  assign mis_in = |addr[OB-1:0];
  assign idx_in = addr[IW+OB-1:OB];
  // upper address bits are deliberately dropped so accesses wrap modulo DEPTH
  assign unused_addr = ^(addr >> (IW + OB));
  always_comb begin
    accept = state == IDLE && req;
    done = state == BUSY && cnt == '0;
    state_n = accept ? BUSY : done ? IDLE : state;
    cnt_n = accept ? CW'(LAT - 1) : (state == BUSY && cnt != '0) ? cnt - CW'(1) : cnt;
    stall = state == IDLE ? req : cnt != '0;
    rvalid = done & op_rd;
    wdone = done & ~op_rd;
    err = done & (mis | both);
    rdata = rvalid ? dreg : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end
  // read wins when both requests are set; the array is read at acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      op_rd <= 1'b0;
      both <= 1'b0;
      mis <= 1'b0;
      idx <= '0;
      wd <= '0;
      dreg <= '0;
    end else if (accept) begin
      op_rd <= memread;
      both <= memread & memwrite;
      mis <= mis_in;
      idx <= idx_in;
      wd <= wdata;
      dreg <= (memread && !mis_in) ? mem[idx_in] : '0;
    end
  end
  // stores commit at the completion edge; reset there aborts the write
  always_ff @(posedge clk) begin
    if (!rst && done && !op_rd && !mis) mem[idx] <= wd;
  end
endmodule

// File: tb/tb_rv_dmem_responder.sv
// tb_rv_dmem_responder: table vectors, corner sequences and random traffic against a memory model
module tb_rv_dmem_responder;
  localparam int LAT = 2;
  logic clk = 1'b0, rst = 1'b1, memread = 1'b0, memwrite = 1'b0;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic rvalid, wdone, stall, err;
  int checks = 0, failures = 0;
  logic [31:0] ref_mem [int];
  typedef struct {
    logic rd;
    logic wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] ed;
    logic ee;
  } vec_t;
  vec_t vt [15];
  rv_dmem_responder #(.AW(32), .DW(32), .DEPTH(1024), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .memread(memread), .memwrite(memwrite), .addr(addr),
    .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .wdone(wdone), .stall(stall), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #1 chk("idle_outputs", {stall, rvalid, wdone, err, rdata}, 64'h0);
    end
  endtask
  // one request: LAT stalled cycles, then a completion cycle; ck=0 skips rdata for unknown words
  task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] ed, input logic ee, input logic ck);
    @(negedge clk);
    memread = rd;
    memwrite = wr;
    addr = a;
    wdata = d;
    #1 chk("stall_req", stall, 1);
    chk("pulse_at_accept", {rvalid, wdone, err}, 0);
    for (int k = 1; k < LAT; k++) begin
      @(negedge clk);
      #1 chk("stall_busy", stall, 1);
      chk("pulse_early", {rvalid, wdone, err}, 0);
    end
    @(negedge clk);
    #1 chk("stall_done", stall, 0);
    chk("rvalid", rvalid, rd);
    chk("wdone", wdone, !rd);
    chk("err", err, ee);
    if (!rd || ck) chk("rdata", rdata, rd ? ed : 32'h0);
    if (wr && !rd && a[1:0] == 2'b00) ref_mem[int'((a >> 2) & 32'h3ff)] = d;
    memread = 1'b0;
    memwrite = 1'b0;
  endtask
  initial begin
    vt[0]  = '{1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 32'h1000, 32'hA5, 32'h0, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 32'h0, 32'h0, 32'hA5, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 32'h2, 32'hFF, 32'h0, 1'b1};
    vt[5]  = '{1'b1, 1'b0, 32'h0, 32'h0, 32'hA5, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 32'h10, 32'h1111, 32'h0, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 32'h14, 32'h2222, 32'h0, 1'b0};
    vt[8]  = '{1'b1, 1'b0, 32'h10, 32'h0, 32'h1111, 1'b0};
    vt[9]  = '{1'b1, 1'b0, 32'h14, 32'h0, 32'h2222, 1'b0};
    vt[10] = '{1'b0, 1'b1, 32'h8, 32'h33, 32'h0, 1'b0};
    vt[11] = '{1'b1, 1'b1, 32'h8, 32'h77, 32'h33, 1'b1};
    vt[12] = '{1'b1, 1'b0, 32'h8, 32'h0, 32'h33, 1'b0};
    vt[13] = '{1'b1, 1'b0, 32'h3, 32'h0, 32'h0, 1'b1};
    vt[14] = '{1'b1, 1'b0, 32'hFFFFF014, 32'h0, 32'h2222, 1'b0};
    repeat (2) @(negedge clk);
    #1 chk("reset_outputs", {stall, rvalid, wdone, err, rdata}, 64'h0);
    rst = 1'b0;
    idle_cycles(10);
    for (int i = 0; i < 15; i++) access(vt[i].rd, vt[i].wr, vt[i].a, vt[i].d, vt[i].ed, vt[i].ee, 1'b1);
    idle_cycles(2);
    // reset in the second stall cycle of a store aborts it
    access(1'b0, 1'b1, 32'h20, 32'h99, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    memwrite = 1'b1;
    addr = 32'h20;
    wdata = 32'h55;
    #1 chk("rst_seq_stall1", stall, 1);
    @(negedge clk);
    #1 chk("rst_seq_stall2", stall, 1);
    rst = 1'b1;
    memwrite = 1'b0;
    @(negedge clk);
    #1 chk("rst_seq_after", {stall, wdone, rvalid, err}, 0);
    rst = 1'b0;
    access(1'b1, 1'b0, 32'h20, 32'h0, 32'h99, 1'b0, 1'b1);
    // random traffic over a small window of words, with wrap bits and occasional misalignment
    for (int i = 0; i < 150; i++) begin
      int op, wi;
      logic rd, wr, mis, known;
      logic [31:0] a, d, ed;
      op = int'($urandom_range(0, 9));
      rd = op <= 4;
      wr = op == 0 || op >= 5;
      wi = int'($urandom_range(0, 15));
      a = ($urandom_range(0, 3) << 12) | (32'(wi) << 2) | (($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0);
      d = $urandom;
      mis = a[1:0] != 2'b00;
      known = mis || ref_mem.exists(wi);
      ed = mis ? 32'h0 : (ref_mem.exists(wi) ? ref_mem[wi] : 32'h0);
      access(rd, wr, a, d, ed, mis || (rd && wr), known);
      if ($urandom_range(0, 3) == 0) idle_cycles(1);
    end
    idle_cycles(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
